// File: rtl/mem_dcache_ctrl.sv
// Load/store sequencer between the EX/MEM register and the data-cache bus port.
// Aligns store data and strobes to the 8-byte lane and right-justifies load data.
module mem_dcache_ctrl #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [2:0]    req_funct3_i,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  output logic [7:0]    bus_wstrb_o,
  input  logic          bus_ready_i,
  input  logic          bus_rvalid_i,
  input  logic [DW-1:0] bus_rdata_i,
  output logic          dcache_data_valid_o,
  output logic [DW-1:0] dcache_data_o,
  output logic          misalign_o
);

  localparam int unsigned OW = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [7:0]    bus_wstrb_q, bus_wstrb_d;
  logic [1:0]    size_q, size_d;
  logic [OW-1:0] off_q, off_d;
  logic [DW-1:0] data_q, data_d;
  logic          misalign_q, misalign_d;

  logic [OW-1:0] off_c;
  logic [7:0]    mask_c;
  logic          misalign_c;
  logic [DW-1:0] lane_mask_c;
  logic          unused_c;

  assign off_c    = req_addr_i[OW-1:0];
  assign unused_c = req_funct3_i[2];

  // Byte mask and natural-alignment test for the incoming request size
  always_comb begin
    mask_c     = 8'h01;
    misalign_c = 1'b0;
    case (req_funct3_i[1:0])
      2'b00: begin mask_c = 8'h01; misalign_c = 1'b0;                end
      2'b01: begin mask_c = 8'h03; misalign_c = off_c[0];            end
      2'b10: begin mask_c = 8'h0F; misalign_c = |off_c[1:0];         end
      2'b11: begin mask_c = 8'hFF; misalign_c = |off_c;              end
    endcase
  end

  // Load-data mask for the registered access size
  always_comb begin
    lane_mask_c = '1;
    case (size_q)
      2'b00: lane_mask_c = DW'(64'h0000_0000_0000_00FF);
      2'b01: lane_mask_c = DW'(64'h0000_0000_0000_FFFF);
      2'b10: lane_mask_c = DW'(64'h0000_0000_FFFF_FFFF);
      2'b11: lane_mask_c = '1;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    size_d      = size_q;
    off_d       = off_q;
    data_d      = data_q;
    misalign_d  = misalign_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (misalign_c) begin
            misalign_d = 1'b1;
            data_d     = '0;
            state_d    = DONE;
          end else begin
            misalign_d  = 1'b0;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we_i;
            bus_addr_d  = {req_addr_i[AW-1:OW], {OW{1'b0}}};
            bus_wdata_d = req_wdata_i << {off_c, 3'b000};
            bus_wstrb_d = req_we_i ? 8'(mask_c << off_c) : 8'h00;
            size_d      = req_funct3_i[1:0];
            off_d       = off_c;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (bus_ready_i) begin
          bus_req_d = 1'b0;
          state_d   = bus_we_q ? DONE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (bus_rvalid_i) begin
          data_d  = (bus_rdata_i >> {off_q, 3'b000}) & lane_mask_c;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      size_q      <= '0;
      off_q       <= '0;
      data_q      <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      size_q      <= size_d;
      off_q       <= off_d;
      data_q      <= data_d;
      misalign_q  <= misalign_d;
    end
  end

  // Non-memory instructions never stall; memory ones release in DONE
  assign dcache_data_valid_o = ((state_q == IDLE) && !req_valid_i) || (state_q == DONE);

  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = bus_we_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign bus_wstrb_o   = bus_wstrb_q;
  assign dcache_data_o = data_q;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_mem_dcache_ctrl.sv
// Directed bench for mem_dcache_ctrl with hand-computed expectations.
module tb_mem_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_we_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [63:0] bus_addr_o;
  logic [63:0] bus_wdata_o;
  logic [7:0]  bus_wstrb_o;
  logic        bus_ready_i;
  logic        bus_rvalid_i;
  logic [63:0] bus_rdata_i;
  logic        dcache_data_valid_o;
  logic [63:0] dcache_data_o;
  logic        misalign_o;

  int errs;
  int checks;

  mem_dcache_ctrl #(.AW(64), .DW(64)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid_i         (req_valid_i),
    .req_we_i            (req_we_i),
    .req_addr_i          (req_addr_i),
    .req_wdata_i         (req_wdata_i),
    .req_funct3_i        (req_funct3_i),
    .bus_req_o           (bus_req_o),
    .bus_we_o            (bus_we_o),
    .bus_addr_o          (bus_addr_o),
    .bus_wdata_o         (bus_wdata_o),
    .bus_wstrb_o         (bus_wstrb_o),
    .bus_ready_i         (bus_ready_i),
    .bus_rvalid_i        (bus_rvalid_i),
    .bus_rdata_i         (bus_rdata_i),
    .dcache_data_valid_o (dcache_data_valid_o),
    .dcache_data_o       (dcache_data_o),
    .misalign_o          (misalign_o)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value to its expected value
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let combinational outputs settle
  task automatic drive_req(input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [2:0] f3);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_funct3_i = f3;
    #1;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_funct3_i = '0; bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    step(); step();
    rst = 1'b0;

    // Reset state and idle behaviour
    check("rst_bus_req", 64'(bus_req_o), 64'h0);
    check("rst_wstrb", 64'(bus_wstrb_o), 64'h0);
    check("rst_data", dcache_data_o, 64'h0);
    check("rst_misalign", 64'(misalign_o), 64'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_valid", 64'(dcache_data_valid_o), 64'h1);
      check("idle_bus_req", 64'(bus_req_o), 64'h0);
    end

    // ld 0x1000: ready cycle 1, rvalid cycle 2, DONE cycle 3
    drive_req(1'b0, 64'h1000, 64'h0, 3'b011);
    check("ld_c0_valid", 64'(dcache_data_valid_o), 64'h0);
    step();
    check("ld_c1_req", 64'(bus_req_o), 64'h1);
    check("ld_c1_addr", bus_addr_o, 64'h1000);
    check("ld_c1_wstrb", 64'(bus_wstrb_o), 64'h0);
    check("ld_c1_we", 64'(bus_we_o), 64'h0);
    check("ld_c1_valid", 64'(dcache_data_valid_o), 64'h0);
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    check("ld_c2_req", 64'(bus_req_o), 64'h0);
    check("ld_c2_valid", 64'(dcache_data_valid_o), 64'h0);
    bus_rvalid_i = 1'b1; bus_rdata_i = 64'h1122334455667788;
    step();
    bus_rvalid_i = 1'b0;
    check("ld_c3_valid", 64'(dcache_data_valid_o), 64'h1);
    check("ld_c3_data", dcache_data_o, 64'h1122334455667788);
    req_valid_i = 1'b0;
    step();
    check("ld_idle_valid", 64'(dcache_data_valid_o), 64'h1);

    // sh 0x3006 with ready held off for 4 REQ cycles
    drive_req(1'b1, 64'h3006, 64'h000000000000BEEF, 3'b001);
    step();
    for (int i = 0; i < 4; i++) begin
      check("sh_wait_req", 64'(bus_req_o), 64'h1);
      check("sh_wait_addr", bus_addr_o, 64'h3000);
      check("sh_wait_wdata", bus_wdata_o, 64'hBEEF000000000000);
      check("sh_wait_wstrb", 64'(bus_wstrb_o), 64'hC0);
      check("sh_wait_we", 64'(bus_we_o), 64'h1);
      check("sh_wait_valid", 64'(dcache_data_valid_o), 64'h0);
      step();
    end
    check("sh_ready_req", 64'(bus_req_o), 64'h1);
    check("sh_ready_wstrb", 64'(bus_wstrb_o), 64'hC0);
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    check("sh_done_valid", 64'(dcache_data_valid_o), 64'h1);
    check("sh_done_req", 64'(bus_req_o), 64'h0);
    req_valid_i = 1'b0;
    step();

    // Misaligned lw 0x4002, then aligned sw 0x4004 clears misalign
    drive_req(1'b0, 64'h4002, 64'h0, 3'b010);
    check("mis_c0_valid", 64'(dcache_data_valid_o), 64'h0);
    step();
    check("mis_done_valid", 64'(dcache_data_valid_o), 64'h1);
    check("mis_done_flag", 64'(misalign_o), 64'h1);
    check("mis_done_data", dcache_data_o, 64'h0);
    check("mis_done_req", 64'(bus_req_o), 64'h0);
    drive_req(1'b1, 64'h4004, 64'h0000000012345678, 3'b010);
    step();
    check("sw_c0_valid", 64'(dcache_data_valid_o), 64'h0);
    check("sw_c0_hold_mis", 64'(misalign_o), 64'h1);
    step();
    check("sw_c1_mis", 64'(misalign_o), 64'h0);
    check("sw_c1_req", 64'(bus_req_o), 64'h1);
    check("sw_c1_addr", bus_addr_o, 64'h4000);
    check("sw_c1_wstrb", 64'(bus_wstrb_o), 64'hF0);
    check("sw_c1_wdata", bus_wdata_o, 64'h1234567800000000);
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    check("sw_done_valid", 64'(dcache_data_valid_o), 64'h1);
    req_valid_i = 1'b0;
    step();

    // lbu 0x2003; rvalid alongside ready is ignored, real data one cycle late
    drive_req(1'b0, 64'h2003, 64'h0, 3'b100);
    step();
    check("lbu_addr", bus_addr_o, 64'h2000);
    check("lbu_wstrb", 64'(bus_wstrb_o), 64'h0);
    bus_ready_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 64'h5555555555555555;
    step();
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
    check("lbu_wait_valid", 64'(dcache_data_valid_o), 64'h0);
    step();
    check("lbu_wait2_valid", 64'(dcache_data_valid_o), 64'h0);
    bus_rvalid_i = 1'b1; bus_rdata_i = 64'hAABBCCDDEEFF0011;
    step();
    bus_rvalid_i = 1'b0;
    check("lbu_done_valid", 64'(dcache_data_valid_o), 64'h1);
    check("lbu_done_data", dcache_data_o, 64'h00000000000000EE);
    check("lbu_done_mis", 64'(misalign_o), 64'h0);
    req_valid_i = 1'b0;
    step();

    // Reset in WAIT_R, then a stray rvalid must be ignored
    drive_req(1'b0, 64'h5008, 64'h0, 3'b011);
    step();
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    rst = 1'b1; req_valid_i = 1'b0;
    step();
    rst = 1'b0;
    check("wr_rst_req", 64'(bus_req_o), 64'h0);
    check("wr_rst_addr", bus_addr_o, 64'h0);
    check("wr_rst_data", dcache_data_o, 64'h0);
    check("wr_rst_valid", 64'(dcache_data_valid_o), 64'h1);
    bus_rvalid_i = 1'b1; bus_rdata_i = 64'hDEADBEEFCAFEF00D;
    step();
    bus_rvalid_i = 1'b0;
    check("late_rv_data", dcache_data_o, 64'h0);
    check("late_rv_valid", 64'(dcache_data_valid_o), 64'h1);
    step();
    check("late_rv_valid2", 64'(dcache_data_valid_o), 64'h1);
    check("late_rv_req", 64'(bus_req_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
